glb_proc_initiator: RTL and testbench



---
 rtl/glb_proc_initiator_pkg.sv | 29 ++
 rtl/glb_proc_initiator_if.sv | 34 +++
 rtl/glb_resp_fifo.sv | 55 +++++
 rtl/glb_proc_initiator.sv | 121 ++++++++++++
 tb/tb_glb_proc_initiator.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/glb_proc_initiator_pkg.sv
// Shared types for the global buffer processor-packet protocol: tile-chain
// packet layouts and default sizing constants for the host initiator.
package glb_proc_initiator_pkg;

  localparam int GLB_ADDR_WIDTH   = 19;
  localparam int GLB_DATA_WIDTH   = 64;
  localparam int GLB_STRB_WIDTH   = GLB_DATA_WIDTH / 8;
  localparam int GLB_PROC_TIMEOUT = 255;

  // Field widths follow the existing wr / rdrq / rdrs channel layout.
  typedef logic [GLB_STRB_WIDTH-1:0] glb_wr_strb_t;
  typedef logic [GLB_ADDR_WIDTH-1:0] glb_addr_t;
  typedef logic [GLB_DATA_WIDTH-1:0] glb_data_t;

  typedef struct packed {
    logic         wr_en;
    glb_wr_strb_t wr_strb;
    glb_addr_t    wr_addr;
    glb_data_t    wr_data;
    logic         rd_en;
    glb_addr_t    rd_addr;
  } proc_init_packet_t;

  typedef struct packed {
    glb_data_t rd_data;
    logic      rd_data_valid;
  } proc_rdrs_packet_t;

endpackage

// File: rtl/glb_proc_initiator_if.sv
// Host-side request/response port of the processor-packet initiator.
// Handshake: a beat transfers on a clock edge where valid and ready are both
// high; once valid is raised the sender holds valid and payload stable until
// that edge, and ready never depends on valid.
interface glb_proc_initiator_if
  import glb_proc_initiator_pkg::*;
#(
  parameter int ADDR_WIDTH = GLB_ADDR_WIDTH,
  parameter int DATA_WIDTH = GLB_DATA_WIDTH
);

  logic                    req_valid;
  logic                    req_ready;
  logic                    req_write;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [DATA_WIDTH-1:0]   req_data;
  logic [DATA_WIDTH/8-1:0] req_strb;

  logic                    resp_valid;
  logic                    resp_ready;
  logic [DATA_WIDTH-1:0]   resp_data;
  logic                    resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_data, req_strb, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_data, req_strb, resp_ready,
    output req_ready, resp_valid, resp_data, resp_err
  );

endinterface

// File: rtl/glb_resp_fifo.sv
// First-word fall-through response FIFO with occupancy count; head data reads
// as zero while empty so the host port is quiet in reset.
module glb_resp_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 65,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count
);

  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_pop;

  assign out_valid = (count != '0);
  assign do_pop    = pop && out_valid;
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always @(posedge clk) begin
    if (reset_n) assert (!(push && count == FULL_COUNT));
  end

endmodule

// File: rtl/glb_proc_initiator.sv
// Host initiator: turns host requests into one-cycle tile-chain packets and
// returns in-order read responses, with read credits and a timeout watchdog.
module glb_proc_initiator
  import glb_proc_initiator_pkg::*;
#(
  parameter  int ADDR_WIDTH = GLB_ADDR_WIDTH,
  parameter  int DATA_WIDTH = GLB_DATA_WIDTH,
  parameter  int RESP_DEPTH = 4,
  parameter  int TIMEOUT    = GLB_PROC_TIMEOUT,
  localparam int CW         = $clog2(RESP_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  glb_proc_initiator_if.slave  host,
  output proc_init_packet_t    proc_packet_w2e_esto,
  input  proc_rdrs_packet_t    proc_packet_e2w_esti,
  output logic [CW-1:0]        outstanding,
  output logic                 timeout_pulse
);

  localparam int              WDW     = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0]  WD_LAST = WDW'(TIMEOUT - 1);
  localparam logic [CW:0]     CREDITS = (CW + 1)'(RESP_DEPTH);
  // A dead chain can time out more reads than the credit limit over time.
  localparam int              DROP_W  = 16;

  logic                  ready_en;
  logic [CW-1:0]         fifo_count;
  logic [DROP_W-1:0]     drop_cnt;
  logic [WDW-1:0]        wd_cnt;
  logic                  credit_ok;
  logic                  accept;
  logic                  accept_rd;
  logic                  rsp_in;
  logic                  rsp_drop;
  logic                  rsp_keep;
  logic                  rsp_unexp;
  logic                  wd_fire;
  logic                  push;
  logic [DATA_WIDTH:0]   push_entry;
  logic [DATA_WIDTH:0]   head_entry;
  logic                  head_valid;

  assign credit_ok      = ({1'b0, outstanding} + {1'b0, fifo_count}) < CREDITS;
  assign host.req_ready = ready_en & credit_ok;
  assign accept         = host.req_valid & host.req_ready;
  assign accept_rd      = accept & ~host.req_write;

  assign rsp_in    = proc_packet_e2w_esti.rd_data_valid;
  assign rsp_drop  = rsp_in & (drop_cnt != '0);
  assign rsp_keep  = rsp_in & (drop_cnt == '0) & (outstanding != '0);
  assign rsp_unexp = rsp_in & (drop_cnt == '0) & (outstanding == '0);
  // Any arriving response, even one being dropped, suppresses the timeout.
  assign wd_fire   = (outstanding != '0) & (wd_cnt == WD_LAST) & ~rsp_in;

  assign push       = rsp_keep | wd_fire;
  assign push_entry = wd_fire ? {1'b1, {DATA_WIDTH{1'b0}}}
                              : {1'b0, proc_packet_e2w_esti.rd_data};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready_en             <= 1'b0;
      outstanding          <= '0;
      drop_cnt             <= '0;
      wd_cnt               <= '0;
      timeout_pulse        <= 1'b0;
      proc_packet_w2e_esto <= '0;
    end else begin
      ready_en      <= 1'b1;
      timeout_pulse <= wd_fire;

      case ({accept_rd, push})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase

      if (wd_fire && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
      else if (rsp_drop)             drop_cnt <= drop_cnt - 1'b1;

      if (rsp_in || wd_fire || outstanding == '0) wd_cnt <= '0;
      else                                        wd_cnt <= wd_cnt + 1'b1;

      proc_packet_w2e_esto <= '0;
      if (accept) begin
        if (host.req_write) begin
          proc_packet_w2e_esto.wr_en   <= 1'b1;
          proc_packet_w2e_esto.wr_strb <= host.req_strb;
          proc_packet_w2e_esto.wr_addr <= host.req_addr;
          proc_packet_w2e_esto.wr_data <= host.req_data;
        end else begin
          proc_packet_w2e_esto.rd_en   <= 1'b1;
          proc_packet_w2e_esto.rd_addr <= host.req_addr;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (reset_n) assert (!rsp_unexp);
  end

  glb_resp_fifo #(
    .DEPTH (RESP_DEPTH),
    .WIDTH (DATA_WIDTH + 1)
  ) u_resp_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (host.resp_ready),
    .out_valid (head_valid),
    .out_data  (head_entry),
    .count     (fifo_count)
  );

  assign host.resp_valid = head_valid;
  assign host.resp_err   = head_entry[DATA_WIDTH];
  assign host.resp_data  = head_entry[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_glb_proc_initiator.sv
// Directed bench for glb_proc_initiator with RESP_DEPTH=4 and TIMEOUT=8.
module tb_glb_proc_initiator;
  import glb_proc_initiator_pkg::*;

  localparam int RESP_DEPTH = 4;
  localparam int TIMEOUT    = 8;
  localparam int CW         = $clog2(RESP_DEPTH + 1);

  logic              clk     = 1'b0;
  logic              reset_n = 1'b0;
  proc_init_packet_t pkt;
  proc_rdrs_packet_t rdrs;
  logic [CW-1:0]     outstanding;
  logic              timeout_pulse;
  int                checks = 0;
  int                errors = 0;

  glb_proc_initiator_if host ();

  glb_proc_initiator #(
    .RESP_DEPTH (RESP_DEPTH),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .host                 (host),
    .proc_packet_w2e_esto (pkt),
    .proc_packet_e2w_esti (rdrs),
    .outstanding          (outstanding),
    .timeout_pulse        (timeout_pulse)
  );

  // clock / reset
  always #5 clk = ~clk;

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_req();
    host.req_valid = 1'b0;
    host.req_write = 1'b0;
    host.req_addr  = '0;
    host.req_data  = '0;
    host.req_strb  = '0;
  endtask

  task automatic drive_read(input logic [18:0] addr);
    host.req_valid = 1'b1;
    host.req_write = 1'b0;
    host.req_addr  = addr;
    host.req_data  = '0;
    host.req_strb  = '0;
  endtask

  task automatic tile_rsp(input logic [63:0] data);
    rdrs.rd_data       = data;
    rdrs.rd_data_valid = 1'b1;
  endtask

  task automatic tile_idle();
    rdrs = '0;
  endtask

  task automatic pop_one();
    host.resp_ready = 1'b1;
    step();
    host.resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    idle_req();
    tile_idle();
    host.resp_ready = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    checks++; if (host.req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready got %0b want 0", host.req_ready); end
    checks++; if (host.resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid got %0b want 0", host.resp_valid); end
    checks++; if (outstanding !== '0) begin errors++; $display("FAIL rst_outstanding got %0d want 0", outstanding); end
    checks++; if (pkt !== '0) begin errors++; $display("FAIL rst_packet got %h want 0", pkt); end
    checks++; if (timeout_pulse !== 1'b0) begin errors++; $display("FAIL rst_timeout_pulse got %0b want 0", timeout_pulse); end
    checks++; if (host.resp_data !== '0 || host.resp_err !== 1'b0) begin errors++; $display("FAIL rst_resp_fields got %h/%0b want 0/0", host.resp_data, host.resp_err); end
    reset_n = 1'b1;
    step();
    checks++; if (host.req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after got %0b want 1", host.req_ready); end
  endtask

  task automatic test_write();
    proc_init_packet_t exp;
    host.req_valid = 1'b1;
    host.req_write = 1'b1;
    host.req_addr  = 19'h100;
    host.req_data  = 64'hA5A5_0000_0000_5A5A;
    host.req_strb  = 8'hFF;
    checks++; if (host.req_ready !== 1'b1) begin errors++; $display("FAIL wr_ready got %0b want 1", host.req_ready); end
    step();
    idle_req();
    exp         = '0;
    exp.wr_en   = 1'b1;
    exp.wr_strb = 8'hFF;
    exp.wr_addr = 19'h100;
    exp.wr_data = 64'hA5A5_0000_0000_5A5A;
    checks++; if (pkt !== exp) begin errors++; $display("FAIL wr_packet got %h want %h", pkt, exp); end
    checks++; if (outstanding !== '0) begin errors++; $display("FAIL wr_outstanding got %0d want 0", outstanding); end
    step();
    checks++; if (pkt !== '0) begin errors++; $display("FAIL wr_packet_idle got %h want 0", pkt); end
  endtask

  task automatic test_read();
    proc_init_packet_t exp;
    drive_read(19'h200);
    step();
    idle_req();
    exp         = '0;
    exp.rd_en   = 1'b1;
    exp.rd_addr = 19'h200;
    checks++; if (pkt !== exp) begin errors++; $display("FAIL rd_packet got %h want %h", pkt, exp); end
    checks++; if (outstanding !== 3'd1) begin errors++; $display("FAIL rd_outstanding_1 got %0d want 1", outstanding); end
    repeat (4) step();
    tile_rsp(64'h1234);
    checks++; if (host.resp_valid !== 1'b0) begin errors++; $display("FAIL rd_early_valid got %0b want 0", host.resp_valid); end
    step();
    tile_idle();
    checks++; if (host.resp_valid !== 1'b1) begin errors++; $display("FAIL rd_resp_valid got %0b want 1", host.resp_valid); end
    checks++; if (host.resp_data !== 64'h1234 || host.resp_err !== 1'b0) begin errors++; $display("FAIL rd_resp got %h/%0b want 1234/0", host.resp_data, host.resp_err); end
    checks++; if (outstanding !== '0) begin errors++; $display("FAIL rd_outstanding_0 got %0d want 0", outstanding); end
    pop_one();
    checks++; if (host.resp_valid !== 1'b0) begin errors++; $display("FAIL rd_popped got %0b want 0", host.resp_valid); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp_data;
    host.resp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_read(19'h300 + 19'(i * 8));
      checks++; if (host.req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_%0d got %0b want 1", i, host.req_ready); end
      step();
    end
    drive_read(19'h340);
    checks++; if (host.req_ready !== 1'b0) begin errors++; $display("FAIL b2b_credit_stall got %0b want 0", host.req_ready); end
    checks++; if (outstanding !== 3'd4) begin errors++; $display("FAIL b2b_outstanding got %0d want 4", outstanding); end
    for (int i = 0; i < 4; i++) begin
      tile_rsp(64'h11 * 64'(i + 1));
      step();
      if (i == 0) begin
        idle_req();
        checks++; if (pkt !== '0) begin errors++; $display("FAIL b2b_no_issue got %h want 0", pkt); end
      end
    end
    tile_idle();
    checks++; if (outstanding !== '0) begin errors++; $display("FAIL b2b_all_answered got %0d want 0", outstanding); end
    checks++; if (host.req_ready !== 1'b0) begin errors++; $display("FAIL b2b_fifo_full_ready got %0b want 0", host.req_ready); end
    step();
    checks++; if (host.resp_valid !== 1'b1 || host.resp_data !== 64'h11) begin errors++; $display("FAIL b2b_head_hold got %0b/%h want 1/11", host.resp_valid, host.resp_data); end
    host.resp_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      step();
      exp_data = 64'h11 * 64'(i + 1);
      checks++; if (host.resp_data !== exp_data) begin errors++; $display("FAIL b2b_order_%0d got %h want %h", i, host.resp_data, exp_data); end
      checks++; if (host.req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_back_%0d got %0b want 1", i, host.req_ready); end
    end
    step();
    host.resp_ready = 1'b0;
    checks++; if (host.resp_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained got %0b want 0", host.resp_valid); end
  endtask

  task automatic test_timeout();
    drive_read(19'h400);
    step();
    idle_req();
    for (int k = 1; k < 9; k++) begin
      checks++; if ({host.resp_valid, timeout_pulse} !== 2'b00) begin errors++; $display("FAIL to_wait_c%0d got %b want 00", k, {host.resp_valid, timeout_pulse}); end
      step();
    end
    checks++; if (host.resp_valid !== 1'b1 || host.resp_err !== 1'b1) begin errors++; $display("FAIL to_err_resp got %0b/%0b want 1/1", host.resp_valid, host.resp_err); end
    checks++; if (host.resp_data !== '0) begin errors++; $display("FAIL to_err_data got %h want 0", host.resp_data); end
    checks++; if (timeout_pulse !== 1'b1) begin errors++; $display("FAIL to_pulse got %0b want 1", timeout_pulse); end
    checks++; if (outstanding !== '0) begin errors++; $display("FAIL to_outstanding got %0d want 0", outstanding); end
    step();
    checks++; if (timeout_pulse !== 1'b0) begin errors++; $display("FAIL to_pulse_width got %0b want 0", timeout_pulse); end
    checks++; if (host.resp_valid !== 1'b1 || host.resp_err !== 1'b1) begin errors++; $display("FAIL to_err_hold got %0b/%0b want 1/1", host.resp_valid, host.resp_err); end
    pop_one();
    repeat (9) step();
    tile_rsp(64'hDEAD);
    step();
    tile_idle();
    checks++; if (host.resp_valid !== 1'b0) begin errors++; $display("FAIL to_late_dropped got %0b want 0", host.resp_valid); end
    checks++; if (outstanding !== '0) begin errors++; $display("FAIL to_late_outstanding got %0d want 0", outstanding); end
  endtask

  task automatic test_resp_on_timeout();
    drive_read(19'h500);
    step();
    idle_req();
    repeat (7) step();
    tile_rsp(64'hBEEF);
    step();
    tile_idle();
    checks++; if (host.resp_valid !== 1'b1 || host.resp_err !== 1'b0) begin errors++; $display("FAIL race_resp got %0b/%0b want 1/0", host.resp_valid, host.resp_err); end
    checks++; if (host.resp_data !== 64'hBEEF) begin errors++; $display("FAIL race_data got %h want beef", host.resp_data); end
    checks++; if (timeout_pulse !== 1'b0) begin errors++; $display("FAIL race_no_pulse got %0b want 0", timeout_pulse); end
    checks++; if (outstanding !== '0) begin errors++; $display("FAIL race_outstanding got %0d want 0", outstanding); end
    pop_one();
    checks++; if (host.resp_valid !== 1'b0 || timeout_pulse !== 1'b0) begin errors++; $display("FAIL race_quiet got %0b/%0b want 0/0", host.resp_valid, timeout_pulse); end
    drive_read(19'h508);
    step();
    idle_req();
    step();
    tile_rsp(64'h5151);
    step();
    tile_idle();
    checks++; if (host.resp_valid !== 1'b1 || host.resp_data !== 64'h5151) begin errors++; $display("FAIL race_no_drop got %0b/%h want 1/5151", host.resp_valid, host.resp_data); end
    pop_one();
  endtask

  task automatic test_reset_mid();
    host.resp_ready = 1'b0;
    drive_read(19'h600);
    step();
    idle_req();
    tile_rsp(64'h6060);
    step();
    tile_idle();
    drive_read(19'h608);
    step();
    drive_read(19'h610);
    step();
    idle_req();
    checks++; if (outstanding !== 3'd2 || host.resp_valid !== 1'b1) begin errors++; $display("FAIL mid_setup got %0d/%0b want 2/1", outstanding, host.resp_valid); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (host.resp_valid !== 1'b0) begin errors++; $display("FAIL mid_resp_valid got %0b want 0", host.resp_valid); end
    checks++; if (outstanding !== '0) begin errors++; $display("FAIL mid_outstanding got %0d want 0", outstanding); end
    checks++; if (host.req_ready !== 1'b0) begin errors++; $display("FAIL mid_req_ready got %0b want 0", host.req_ready); end
    @(negedge clk);
    reset_n = 1'b1;
    step();
    checks++; if (host.req_ready !== 1'b1 || host.resp_valid !== 1'b0) begin errors++; $display("FAIL mid_after got %0b/%0b want 1/0", host.req_ready, host.resp_valid); end
    drive_read(19'h700);
    step();
    idle_req();
    checks++; if (outstanding !== 3'd1) begin errors++; $display("FAIL mid_post_issue got %0d want 1", outstanding); end
    step();
    tile_rsp(64'hCAFE);
    step();
    tile_idle();
    checks++; if (host.resp_valid !== 1'b1 || host.resp_data !== 64'hCAFE || host.resp_err !== 1'b0) begin errors++; $display("FAIL mid_post_resp got %0b/%h/%0b want 1/cafe/0", host.resp_valid, host.resp_data, host.resp_err); end
    checks++; if (outstanding !== '0) begin errors++; $display("FAIL mid_post_outstanding got %0d want 0", outstanding); end
    pop_one();
  endtask

  initial begin
    idle_req();
    tile_idle();
    host.resp_ready = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_timeout();
    test_resp_on_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
